// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Freeze/flush controller for a five-stage pipeline that shares one SRAM
// port. It arbitrates between three stall sources:
//   1. an SRAM access that has not completed (freezes the whole pipe),
//   2. a taken branch resolved in EXE (squashes IF/ID and ID/EXE),
//   3. a load-use / RAW hazard (one-cycle bubble into ID/EXE).
// Memory freeze outranks the branch flush, which outranks the hazard bubble.
// A memory access that waits MEM_TIMEOUT cycles in MEM_WAIT is abandoned
// and reported with a one-cycle mem_abort pulse.
//
// Parameters
//   MEM_TIMEOUT  max SRAM wait cycles before abort (1..255)
//   CNT_W        width of the saturating stall/flush performance counters
//
// Ports
//   clk           in   sole clock, all state on rising edge
//   rst           in   synchronous active-high reset
//   hazard        in   load-use / RAW hazard from hazard detection unit
//   branch_taken  in   taken branch resolved in EXE
//   mem_req       in   MEM stage holds a load or store
//   sram_ready    in   SRAM access completes this cycle
//   freeze_pc     out  hold PC register
//   freeze_if_id  out  hold IF/ID register
//   freeze_all    out  hold ID/EXE, EXE/MEM, MEM/WB and status register
//   flush_if_id   out  clear IF/ID to NOP
//   flush_id_exe  out  clear ID/EXE control bits
//   mem_abort     out  one-cycle pulse on SRAM timeout
//   stall_cnt     out  cycles with freeze_pc asserted (saturating)
//   flush_cnt     out  branch flushes performed (saturating)
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             freeze_all,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             mem_abort,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ABORT    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Raw (pre-reset-gating) decode of the FSM.
    logic mem_freeze;
    logic abort_raw;

    // -------------------------------------------------------------------------
    // Memory-wait FSM: next state, wait counter and memory freeze request.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_freeze = 1'b0;
        abort_raw  = 1'b0;
        case (state_q)
            RUN: begin
                // sram_ready only matters when an access is actually pending;
                // ready in the same cycle as the request is a zero-wait access.
                if (mem_req && !sram_ready) begin
                    mem_freeze = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    wait_cnt_d = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (sram_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    mem_freeze = 1'b1;
                    if (wait_cnt_q == TIMEOUT_VAL) begin
                        state_d    = ABORT;
                        wait_cnt_d = 8'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ABORT: begin
                // Single cycle: pipeline is released so the aborted
                // instruction can be retired/trapped, then back to RUN.
                abort_raw  = 1'b1;
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Freeze / flush arbitration. Everything is forced low during reset so a
    // reset arriving mid-wait releases the pipeline in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        freeze_all   = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        mem_abort    = 1'b0;
        if (!rst) begin
            mem_abort = abort_raw;
            if (mem_freeze) begin
                // Whole pipe holds; a pending branch stays in EXE and is
                // flushed on the first unfrozen cycle instead.
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                freeze_all   = 1'b1;
            end else if (branch_taken) begin
                // Wrong-path instructions in IF/ID and ID/EXE are squashed;
                // any hazard they raised is moot.
                flush_if_id  = 1'b1;
                flush_id_exe = 1'b1;
            end else if (hazard) begin
                // Bubble: hold the consumer in ID, inject NOP into EXE.
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                flush_id_exe = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Saturating performance counters: index 0 = stall, 1 = flush.
    // -------------------------------------------------------------------------
    logic [1:0] cnt_inc;
    assign cnt_inc[0] = freeze_pc;
    assign cnt_inc[1] = flush_if_id;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign stall_cnt = g_cnt[0].cnt_q;
    assign flush_cnt = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int TMO = 4;

    logic clk;
    logic rst, hazard, branch_taken, mem_req, sram_ready;

    logic a_fpc, a_fif, a_fall, a_flif, a_flie, a_ab;
    logic [15:0] a_stall, a_flush;
    logic b_fpc, b_fif, b_fall, b_flif, b_flie, b_ab;
    logic [1:0] b_stall, b_flush;

    int n_checks = 0;
    int n_err    = 0;

    // Wide-counter instance
    pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .sram_ready(sram_ready),
        .freeze_pc(a_fpc), .freeze_if_id(a_fif), .freeze_all(a_fall),
        .flush_if_id(a_flif), .flush_id_exe(a_flie), .mem_abort(a_ab),
        .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    // Narrow-counter instance to exercise saturation
    pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .sram_ready(sram_ready),
        .freeze_pc(b_fpc), .freeze_if_id(b_fif), .freeze_all(b_fall),
        .flush_if_id(b_flif), .flush_id_exe(b_flie), .mem_abort(b_ab),
        .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit r, h, b, m, y;
        bit fpc, fif, fall, flif, flie, ab;
        int stall; // -1: no counter check on this row
        int flush;
    } vec_t;

    vec_t vecs[$];

    function automatic void put(bit r, bit h, bit b, bit m, bit y,
                                bit fpc, bit fif, bit fall, bit flif, bit flie, bit ab,
                                int st, int fc);
        vec_t v;
        v.r = r; v.h = h; v.b = b; v.m = m; v.y = y;
        v.fpc = fpc; v.fif = fif; v.fall = fall; v.flif = flif; v.flie = flie; v.ab = ab;
        v.stall = st; v.flush = fc;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_outs(input string tag, input bit fpc, input bit fif, input bit fall,
                              input bit flif, input bit flie, input bit ab);
        chk({tag, ".a.freeze_pc"},    32'(a_fpc),  32'(fpc));
        chk({tag, ".a.freeze_if_id"}, 32'(a_fif),  32'(fif));
        chk({tag, ".a.freeze_all"},   32'(a_fall), 32'(fall));
        chk({tag, ".a.flush_if_id"},  32'(a_flif), 32'(flif));
        chk({tag, ".a.flush_id_exe"}, 32'(a_flie), 32'(flie));
        chk({tag, ".a.mem_abort"},    32'(a_ab),   32'(ab));
        chk({tag, ".b.freeze_pc"},    32'(b_fpc),  32'(fpc));
        chk({tag, ".b.flush_if_id"},  32'(b_flif), 32'(flif));
        chk({tag, ".b.mem_abort"},    32'(b_ab),   32'(ab));
    endtask

    task automatic check_cnts(input string tag, input int st, input int fc);
        chk({tag, ".a.stall_cnt"}, 32'(a_stall), 32'(sat(st, 65535)));
        chk({tag, ".a.flush_cnt"}, 32'(a_flush), 32'(sat(fc, 65535)));
        chk({tag, ".b.stall_cnt"}, 32'(b_stall), 32'(sat(st, 3)));
        chk({tag, ".b.flush_cnt"}, 32'(b_flush), 32'(sat(fc, 3)));
    endtask

    // Reference model state: counts consecutive memory-stalled cycles of the
    // current access; after TMO+1 stalled cycles the next cycle is an abort.
    int  m_streak;
    bit  m_in_access;
    bit  m_abort_next;
    int  m_stall, m_flush;
    bit  m_valid;

    initial begin
        rst = 1'b1; hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; sram_ready = 1'b0;

        //   r h b m y   fpc fif fall flif flie ab   stall flush(before this cycle)
        put(1,1,1,1,0,  0,0,0,0,0,0,  -1,-1); // 0 reset overrides all inputs
        put(0,0,0,0,0,  0,0,0,0,0,0,   0, 0); // 1 idle
        put(0,1,1,0,0,  0,0,0,1,1,0,   0, 0); // 2 branch beats hazard
        put(0,1,0,0,0,  1,1,0,0,1,0,   0, 1); // 3 hazard bubble
        put(0,0,0,1,1,  0,0,0,0,0,0,   1, 1); // 4 zero-wait access
        put(0,0,0,0,1,  0,0,0,0,0,0,   1, 1); // 5 ready ignored w/o request
        put(0,0,0,1,0,  1,1,1,0,0,0,   1, 1); // 6 wait 1
        put(0,0,0,1,0,  1,1,1,0,0,0,   2, 1); // 7 wait 2
        put(0,0,0,1,0,  1,1,1,0,0,0,   3, 1); // 8 wait 3
        put(0,0,0,1,1,  0,0,0,0,0,0,   4, 1); // 9 ready: unfreeze
        put(0,0,0,0,0,  0,0,0,0,0,0,   4, 1); // 10 back in RUN (no freeze w/o req)
        put(0,0,1,1,0,  1,1,1,0,0,0,   4, 1); // 11 branch masked by freeze
        put(0,1,1,1,0,  1,1,1,0,0,0,   5, 1); // 12 still masked
        put(0,0,1,1,1,  0,0,0,1,1,0,   6, 1); // 13 first unfrozen: flush
        put(0,0,0,0,0,  0,0,0,0,0,0,   6, 2); // 14 idle
        put(0,0,0,1,0,  1,1,1,0,0,0,   6, 2); // 15 timeout run: freeze 1
        put(0,0,0,1,0,  1,1,1,0,0,0,   7, 2); // 16 freeze 2
        put(0,0,0,1,0,  1,1,1,0,0,0,   8, 2); // 17 freeze 3
        put(0,0,0,1,0,  1,1,1,0,0,0,   9, 2); // 18 freeze 4
        put(0,0,0,1,0,  1,1,1,0,0,0,  10, 2); // 19 freeze 5
        put(0,0,0,1,0,  0,0,0,0,0,1,  11, 2); // 20 abort pulse, no freeze
        put(0,0,0,0,0,  0,0,0,0,0,0,  11, 2); // 21 pulse gone
        put(0,0,0,1,0,  1,1,1,0,0,0,  11, 2); // 22 enter wait
        put(0,0,0,1,0,  1,1,1,0,0,0,  12, 2); // 23 first MEM_WAIT cycle
        put(1,0,1,1,0,  0,0,0,0,0,0,  13, 2); // 24 reset in second MEM_WAIT cycle
        put(0,0,0,0,0,  0,0,0,0,0,0,   0, 0); // 25 cleared, RUN
        put(0,1,0,0,0,  1,1,0,0,1,0,   0, 0); // 26 normal decode resumes
        put(0,0,0,0,0,  0,0,0,0,0,0,   1, 0); // 27 idle

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].r; hazard = vecs[i].h; branch_taken = vecs[i].b;
            mem_req = vecs[i].m; sram_ready = vecs[i].y;
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].fpc, vecs[i].fif, vecs[i].fall,
                       vecs[i].flif, vecs[i].flie, vecs[i].ab);
            if (vecs[i].stall >= 0)
                check_cnts($sformatf("v%0d", i), vecs[i].stall, vecs[i].flush);
        end

        // Randomized phase against the reference model
        m_valid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit r, h, b, m, y;
            bit e_mem, e_ab, e_fpc, e_fif, e_fall, e_flif, e_flie;
            r = (cyc == 0) || ($urandom_range(0, 99) == 0);
            h = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 4) == 0);
            m = ($urandom_range(0, 2) != 0);
            y = ($urandom_range(0, 2) == 0);

            @(negedge clk);
            rst = r; hazard = h; branch_taken = b; mem_req = m; sram_ready = y;
            #1;

            e_mem = 0; e_ab = 0; e_fpc = 0; e_fif = 0; e_fall = 0; e_flif = 0; e_flie = 0;
            if (!r) begin
                e_ab  = m_abort_next;
                e_mem = !m_abort_next && (m_in_access || m) && !y;
                if (e_mem)  begin e_fpc = 1; e_fif = 1; e_fall = 1; end
                else if (b) begin e_flif = 1; e_flie = 1; end
                else if (h) begin e_fpc = 1; e_fif = 1; e_flie = 1; end
            end
            check_outs($sformatf("r%0d", cyc), e_fpc, e_fif, e_fall, e_flif, e_flie, e_ab);
            if (m_valid) check_cnts($sformatf("r%0d", cyc), m_stall, m_flush);

            // Advance model to the state after this clock edge
            if (r) begin
                m_streak = 0; m_in_access = 0; m_abort_next = 0;
                m_stall = 0; m_flush = 0; m_valid = 1;
            end else begin
                if (e_fpc)  m_stall++;
                if (e_flif) m_flush++;
                if (m_abort_next) begin
                    m_abort_next = 0; m_in_access = 0; m_streak = 0;
                end else if (e_mem) begin
                    m_streak++;
                    if (m_streak == TMO + 1) begin
                        m_abort_next = 1; m_in_access = 0; m_streak = 0;
                    end else begin
                        m_in_access = 1;
                    end
                end else begin
                    m_in_access = 0; m_streak = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max SRAM wait cycles before abort (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of stall/flush performance counters.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port hazard  in  1  load-use/RAW hazard from hazard detect unit.
REQ-006 SHALL have port branch_taken  in  1  taken branch resolved in EXE stage.
REQ-007 SHALL have port mem_req  in  1  MEM stage holds MEM_R_EN or MEM_W_EN instruction.
REQ-008 SHALL have port sram_ready  in  1  SRAM access completes this cycle.
REQ-009 SHALL have port freeze_pc  out  1  hold PC register.
REQ-010 SHALL have port freeze_if_id  out  1  hold IF/ID register.
REQ-011 SHALL have port freeze_all  out  1  hold ID/EXE, EXE/MEM, MEM/WB registers and Status Register.
REQ-012 SHALL have port flush_if_id  out  1  clear IF/ID register to NOP.
REQ-013 SHALL have port flush_id_exe  out  1  clear ID/EXE control bits (WB_EN, MEM_R_EN, MEM_W_EN, B, S) to 0.
REQ-014 SHALL have port mem_abort  out  1  one-cycle pulse: SRAM timeout.
REQ-015 SHALL have port stall_cnt  out  CNT_W  cycles with freeze_pc asserted.
REQ-016 SHALL have port flush_cnt  out  CNT_W  branch flushes performed.

Function
REQ-017 SHALL implement FSM states RUN, MEM_WAIT, ABORT.
REQ-018 SHALL in RUN with mem_req=1 and sram_ready=0 transition to MEM_WAIT and load wait counter with 1.
REQ-019 SHALL in MEM_WAIT increment wait counter each cycle; sram_ready=1 -> RUN; wait counter == MEM_TIMEOUT with sram_ready=0 -> ABORT.
REQ-020 SHALL in ABORT assert mem_abort for exactly that one cycle and return to RUN next cycle unconditionally.
REQ-021 SHALL assert freeze_pc, freeze_if_id, freeze_all combinationally whenever (state==RUN and mem_req and !sram_ready) or state==MEM_WAIT and !sram_ready; no freeze in ABORT.
REQ-022 SHALL, when freeze_all=1, force flush_if_id=0 and flush_id_exe=0 regardless of branch_taken/hazard (branch resolves after unfreeze).
REQ-023 SHALL, when not frozen and branch_taken=1, assert flush_if_id=1 and flush_id_exe=1 in that cycle, freeze_pc=0, freeze_if_id=0; hazard ignored.
REQ-024 SHALL, when not frozen, branch_taken=0 and hazard=1, assert freeze_pc=1, freeze_if_id=1, flush_id_exe=1 (bubble), flush_if_id=0.
REQ-025 SHALL priority: memory freeze > branch flush > hazard bubble.
REQ-026 SHALL drive all freeze/flush outputs 0 when none of REQ-021/023/024 apply.
REQ-027 SHALL increment stall_cnt each cycle freeze_pc=1, flush_cnt each cycle flush_if_id=1 (REQ-023 case); both saturate at all-ones, no wrap.
REQ-028 SHALL treat sram_ready=1 in RUN with mem_req=1 as zero-wait access: no freeze, stay RUN.
REQ-029 SHALL ignore sram_ready when mem_req=0 in RUN.

Reset
REQ-030 SHALL on rst=1 at clock edge set state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, mem_abort=0.
REQ-031 SHALL hold all freeze/flush outputs 0 while rst=1, including mid-MEM_WAIT; rst overrides all inputs.
REQ-032 SHALL resume normal decoding the first cycle after rst deasserts.

Verification
REQ-033 SHALL verify: mem_req=1, sram_ready=0 for 3 cycles then 1 -> freeze_all=1 for 3 cycles, 0 on 4th; stall_cnt=3; state RUN after.
REQ-034 SHALL verify: MEM_TIMEOUT=4, mem_req=1, sram_ready held 0 -> freeze 5 cycles, mem_abort pulse 1 cycle, freeze 0 in ABORT cycle.
REQ-035 SHALL verify: branch_taken=1 and hazard=1 same cycle, no mem_req -> flush_if_id=1, flush_id_exe=1, freeze_pc=0; flush_cnt +1.
REQ-036 SHALL verify: branch_taken=1 during SRAM wait -> no flush while frozen; flush asserted first unfrozen cycle branch_taken still 1.
REQ-037 SHALL verify: rst=1 in 2nd MEM_WAIT cycle -> next cycle state RUN, counters 0, all outputs 0.
REQ-038 SHALL verify: stall_cnt preloaded near all-ones via CNT_W=2, 5 stall cycles -> stall_cnt=3, no wrap.
